// File: rtl/bios_pkg.sv
// Shared types for the RAM port arbiter: FSM states, requester ids and the
// registered RAM request, plus the helper that turns a port's inputs into one.
package bios_pkg;

    localparam int RAM_ADDR_MSB = 31;
    localparam int RAM_DATA_MSB = 31;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_READ  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_B = 1'b0,
        PORT_C = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic [RAM_ADDR_MSB:0] addr;
        logic [3:0]            byte_enable;
        logic [RAM_DATA_MSB:0] write_data;
        logic                  is_write;
    } ram_req_t;

    // A write wins over a read raised on the same port; reads drive every byte lane.
    function automatic ram_req_t make_req(
        input logic                  write_req,
        input logic [RAM_ADDR_MSB:0] addr,
        input logic [3:0]            byte_enable,
        input logic [RAM_DATA_MSB:0] write_data
    );
        ram_req_t req;
        req.addr        = addr;
        req.write_data  = write_data;
        req.is_write    = write_req;
        req.byte_enable = write_req ? byte_enable : 4'b1111;
        return req;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone eligible port wins, a tie goes to the
// port that was not granted last.
module rr_pick2
    import bios_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  arb_port_t  last_grant_i,
    output arb_port_t  winner_o,
    output logic       any_o
);

    // Eligible bit 0 is the BIOS port, bit 1 the CPU port.
    always_comb begin
        any_o    = |eligible_i;
        winner_o = PORT_B;
        case (eligible_i)
            2'b01:   winner_o = PORT_B;
            2'b10:   winner_o = PORT_C;
            2'b11:   winner_o = (last_grant_i == PORT_B) ? PORT_C : PORT_B;
            default: winner_o = PORT_B;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the BIOS loader (B) and the CPU (C); before boot
// only B is served, afterwards B and C alternate, one registered access at a time.
module ram_port_arbiter
    import bios_pkg::*;
#(
    parameter int ADDR_WIDTH   = RAM_ADDR_MSB,
    parameter int DATA_WIDTH   = RAM_DATA_MSB,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_booted,

    input  logic                  b_read_req,
    input  logic                  b_write_req,
    input  logic [ADDR_WIDTH:0]   b_addr,
    input  logic [3:0]            b_byte_enable,
    input  logic [DATA_WIDTH:0]   b_write_data,
    output logic                  o_b_done,
    output logic [DATA_WIDTH:0]   o_b_read_data,

    input  logic                  c_read_req,
    input  logic                  c_write_req,
    input  logic [ADDR_WIDTH:0]   c_addr,
    input  logic [3:0]            c_byte_enable,
    input  logic [DATA_WIDTH:0]   c_write_data,
    output logic                  o_c_done,
    output logic [DATA_WIDTH:0]   o_c_read_data,

    output logic                  m_read_req,
    output logic                  m_write_enable,
    output logic [3:0]            m_byte_enable,
    output logic [ADDR_WIDTH:0]   m_addr,
    output logic [DATA_WIDTH:0]   m_write_data,
    input  logic [DATA_WIDTH:0]   i_read_data
);

    arb_state_t            state_q;
    arb_port_t             last_grant_q;
    arb_port_t             owner_q;
    logic [2:0]            cnt_q;
    ram_req_t              m_req_q;
    logic                  m_read_req_q;
    logic                  m_write_enable_q;
    logic                  o_b_done_q;
    logic                  o_c_done_q;
    logic [DATA_WIDTH:0]   o_b_read_data_q;
    logic [DATA_WIDTH:0]   o_c_read_data_q;

    logic [1:0]            eligible_s;
    arb_port_t             winner_s;
    logic                  any_s;
    ram_req_t              launch_req_d;

    // The CPU only competes once the system has booted.
    always_comb begin
        eligible_s[0] = b_read_req | b_write_req;
        eligible_s[1] = (c_read_req | c_write_req) & i_booted;
        if (winner_s == PORT_C) begin
            launch_req_d = make_req(c_write_req, c_addr, c_byte_enable, c_write_data);
        end else begin
            launch_req_d = make_req(b_write_req, b_addr, b_byte_enable, b_write_data);
        end
    end

    rr_pick2 u_pick (
        .eligible_i   (eligible_s),
        .last_grant_i (last_grant_q),
        .winner_o     (winner_s),
        .any_o        (any_s)
    );

    // Transaction FSM; strobes and done pulses default low so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ARB_IDLE;
            last_grant_q     <= PORT_C;
            owner_q          <= PORT_B;
            cnt_q            <= 3'd0;
            m_req_q          <= '0;
            m_read_req_q     <= 1'b0;
            m_write_enable_q <= 1'b0;
            o_b_done_q       <= 1'b0;
            o_c_done_q       <= 1'b0;
            o_b_read_data_q  <= '0;
            o_c_read_data_q  <= '0;
        end else begin
            m_read_req_q     <= 1'b0;
            m_write_enable_q <= 1'b0;
            o_b_done_q       <= 1'b0;
            o_c_done_q       <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (any_s) begin
                        m_req_q      <= launch_req_d;
                        last_grant_q <= winner_s;
                        owner_q      <= winner_s;
                        if (launch_req_d.is_write) begin
                            m_write_enable_q <= 1'b1;
                            state_q          <= ARB_WRITE;
                        end else begin
                            m_read_req_q <= 1'b1;
                            cnt_q        <= 3'(READ_LATENCY);
                            state_q      <= ARB_READ;
                        end
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_WRITE: begin
                    o_b_done_q <= (owner_q == PORT_B);
                    o_c_done_q <= (owner_q == PORT_C);
                    state_q    <= ARB_DONE;
                end
                ARB_READ: begin
                    if (cnt_q == 3'd0) begin
                        if (owner_q == PORT_C) begin
                            o_c_read_data_q <= i_read_data;
                            o_c_done_q      <= 1'b1;
                        end else begin
                            o_b_read_data_q <= i_read_data;
                            o_b_done_q      <= 1'b1;
                        end
                        state_q <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ARB_DONE: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign m_read_req     = m_read_req_q;
    assign m_write_enable = m_write_enable_q;
    assign m_byte_enable  = m_req_q.byte_enable;
    assign m_addr         = m_req_q.addr;
    assign m_write_data   = m_req_q.write_data;
    assign o_b_done       = o_b_done_q;
    assign o_c_done       = o_c_done_q;
    assign o_b_read_data  = o_b_read_data_q;
    assign o_c_read_data  = o_c_read_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a vector table of single transactions on
// a READ_LATENCY=1 instance plus hand sequences, and a READ_LATENCY=3 instance.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_booted;
    logic        b_read_req, b_write_req, c_read_req, c_write_req;
    logic [31:0] b_addr, b_write_data, c_addr, c_write_data;
    logic [3:0]  b_byte_enable, c_byte_enable;

    logic        o_b_done, o_c_done, m_read_req, m_write_enable;
    logic [31:0] o_b_read_data, o_c_read_data, m_addr, m_write_data, i_read_data;
    logic [3:0]  m_byte_enable;

    logic        d3_b_done, d3_c_done, d3_m_rd, d3_m_we;
    logic [31:0] d3_b_rd, d3_c_rd, d3_m_addr, d3_m_wd, d3_i_rd;
    logic [3:0]  d3_m_be;

    logic [31:0] mem1 [0:255];
    logic [31:0] rd1;
    logic [31:0] p3_0, p3_1, p3_2;

    int          nerr = 0;
    int          nchk = 0;
    logic [31:0] trk_b, trk_c;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .i_booted(i_booted),
        .b_read_req(b_read_req), .b_write_req(b_write_req), .b_addr(b_addr),
        .b_byte_enable(b_byte_enable), .b_write_data(b_write_data),
        .o_b_done(o_b_done), .o_b_read_data(o_b_read_data),
        .c_read_req(c_read_req), .c_write_req(c_write_req), .c_addr(c_addr),
        .c_byte_enable(c_byte_enable), .c_write_data(c_write_data),
        .o_c_done(o_c_done), .o_c_read_data(o_c_read_data),
        .m_read_req(m_read_req), .m_write_enable(m_write_enable),
        .m_byte_enable(m_byte_enable), .m_addr(m_addr),
        .m_write_data(m_write_data), .i_read_data(i_read_data)
    );

    ram_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .i_booted(i_booted),
        .b_read_req(b_read_req), .b_write_req(b_write_req), .b_addr(b_addr),
        .b_byte_enable(b_byte_enable), .b_write_data(b_write_data),
        .o_b_done(d3_b_done), .o_b_read_data(d3_b_rd),
        .c_read_req(c_read_req), .c_write_req(c_write_req), .c_addr(c_addr),
        .c_byte_enable(c_byte_enable), .c_write_data(c_write_data),
        .o_c_done(d3_c_done), .o_c_read_data(d3_c_rd),
        .m_read_req(d3_m_rd), .m_write_enable(d3_m_we),
        .m_byte_enable(d3_m_be), .m_addr(d3_m_addr),
        .m_write_data(d3_m_wd), .i_read_data(d3_i_rd)
    );

    // RAM with one cycle of read latency and byte-lane writes.
    always @(posedge clk) begin
        if (m_write_enable) begin
            for (int l = 0; l < 4; l++) begin
                if (m_byte_enable[l]) mem1[m_addr[7:0]][8*l +: 8] <= m_write_data[8*l +: 8];
            end
        end
        rd1 <= mem1[m_addr[7:0]];
    end
    assign i_read_data = rd1;

    // Read-only memory with three cycles of latency for the second instance.
    always @(posedge clk) begin
        p3_0 <= (d3_m_addr[7:0] == 8'h10) ? 32'hDEADBEEF : 32'h0000_0000;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign d3_i_rd = p3_2;

    typedef struct {
        logic        booted;
        logic        brd, bwr;
        logic [31:0] baddr;
        logic [3:0]  bbe;
        logic [31:0] bwd;
        logic        crd, cwr;
        logic [31:0] caddr;
        logic [3:0]  cbe;
        logic [31:0] cwd;
        int          e_port;   // 0 none, 1 B, 2 C
        int          e_lat;    // negedges from drive to done pulse
        logic        e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_data;   // write data for writes, read data for reads
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_rd"},   32'(m_read_req),     32'd0);
        check({tag, "_m_we"},   32'(m_write_enable), 32'd0);
        check({tag, "_m_be"},   32'(m_byte_enable),  32'd0);
        check({tag, "_m_addr"}, m_addr,              32'd0);
        check({tag, "_m_wd"},   m_write_data,        32'd0);
        check({tag, "_b_done"}, 32'(o_b_done),       32'd0);
        check({tag, "_c_done"}, 32'(o_c_done),       32'd0);
        check({tag, "_b_rd"},   o_b_read_data,       32'd0);
        check({tag, "_c_rd"},   o_c_read_data,       32'd0);
    endtask

    task automatic drop_reqs();
        b_read_req = 1'b0; b_write_req = 1'b0;
        c_read_req = 1'b0; c_write_req = 1'b0;
    endtask

    // Watches the RL=1 instance until the first done pulse or maxc negedges.
    task automatic watch(input int maxc, output int lat, output int port,
                         output int nwe, output int nrd, output logic [31:0] ma,
                         output logic [3:0] mbe, output logic [31:0] mwd,
                         output logic [31:0] rdat);
        lat = 0; port = 0; nwe = 0; nrd = 0;
        ma = 32'd0; mbe = 4'd0; mwd = 32'd0; rdat = 32'd0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (m_write_enable) begin
                nwe++; ma = m_addr; mbe = m_byte_enable; mwd = m_write_data;
            end
            if (m_read_req) begin
                nrd++; ma = m_addr; mbe = m_byte_enable;
            end
            if (o_b_done || o_c_done) begin
                lat  = k;
                port = o_c_done ? 2 : 1;
                rdat = o_c_done ? o_c_read_data : o_b_read_data;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat, port, nwe, nrd;
        logic [31:0] ma, mwd, rdat;
        logic [3:0]  mbe;
        string p;
        p = $sformatf("v%0d", i);
        i_booted = v.booted;
        b_read_req = v.brd; b_write_req = v.bwr; b_addr = v.baddr;
        b_byte_enable = v.bbe; b_write_data = v.bwd;
        c_read_req = v.crd; c_write_req = v.cwr; c_addr = v.caddr;
        c_byte_enable = v.cbe; c_write_data = v.cwd;
        watch(12, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        drop_reqs();
        check({p, "_port"}, 32'(port), 32'(v.e_port));
        check({p, "_lat"},  32'(lat),  32'(v.e_lat));
        if (v.e_port != 0) begin
            check({p, "_we_cnt"}, 32'(nwe), v.e_wr ? 32'd1 : 32'd0);
            check({p, "_rd_cnt"}, 32'(nrd), v.e_wr ? 32'd0 : 32'd1);
            check({p, "_m_addr"}, ma, v.e_addr);
            check({p, "_m_be"},   32'(mbe), 32'(v.e_be));
            if (v.e_wr) begin
                check({p, "_m_wd"}, mwd, v.e_data);
            end else begin
                check({p, "_rdata"}, rdat, v.e_data);
                if (v.e_port == 1) trk_b = v.e_data;
                else               trk_c = v.e_data;
            end
        end
        check({p, "_b_hold"}, o_b_read_data, trk_b);
        check({p, "_c_hold"}, o_c_read_data, trk_c);
        @(negedge clk);
    endtask

    initial begin
        int lat, port, nwe, nrd, cb, cc, lat3, nrd3;
        logic [31:0] ma, mwd, rdat, rd3;
        logic [3:0]  mbe;

        //          bt  brd  bwr  baddr        bbe      bwd            crd  cwr  caddr        cbe      cwd            port lat wr    addr         be       data
        vecs[0]  = '{1'b0,1'b0,1'b1,32'h10,4'b0001,32'hDEADBEEF, 1'b1,1'b0,32'h30,4'b1111,32'h0,        1, 2, 1'b1, 32'h10, 4'b0001, 32'hDEADBEEF};
        vecs[1]  = '{1'b0,1'b0,1'b1,32'h10,4'b1111,32'hDEADBEEF, 1'b1,1'b0,32'h30,4'b1111,32'h0,        1, 2, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0, 4'b0000,32'h0,        1'b1,1'b0,32'h30,4'b1111,32'h0,        0, 0, 1'b0, 32'h0,  4'b0000, 32'h0};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h10,4'b0000,32'h0,        1'b0,1'b1,32'h30,4'b1111,32'h77,       1, 3, 1'b0, 32'h10, 4'b1111, 32'hDEADBEEF};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'h0, 4'b0000,32'h0,        1'b0,1'b1,32'h20,4'b1111,32'h11111111, 2, 2, 1'b1, 32'h20, 4'b1111, 32'h11111111};
        vecs[5]  = '{1'b1,1'b0,1'b0,32'h0, 4'b0000,32'h0,        1'b1,1'b0,32'h20,4'b0000,32'h0,        2, 3, 1'b0, 32'h20, 4'b1111, 32'h11111111};
        vecs[6]  = '{1'b1,1'b0,1'b1,32'h40,4'b1111,32'hA5A5A5A5, 1'b0,1'b0,32'h0, 4'b0000,32'h0,        1, 2, 1'b1, 32'h40, 4'b1111, 32'hA5A5A5A5};
        vecs[7]  = '{1'b1,1'b1,1'b0,32'h10,4'b0000,32'h0,        1'b0,1'b1,32'h40,4'b0011,32'h00005A5A, 2, 2, 1'b1, 32'h40, 4'b0011, 32'h00005A5A};
        vecs[8]  = '{1'b1,1'b1,1'b0,32'h40,4'b0000,32'h0,        1'b1,1'b0,32'h20,4'b0000,32'h0,        1, 3, 1'b0, 32'h40, 4'b1111, 32'hA5A55A5A};
        vecs[9]  = '{1'b1,1'b0,1'b1,32'h50,4'b1111,32'hCAFEF00D, 1'b1,1'b0,32'h40,4'b0000,32'h0,        2, 3, 1'b0, 32'h40, 4'b1111, 32'hA5A55A5A};
        vecs[10] = '{1'b1,1'b0,1'b1,32'h50,4'b1111,32'hCAFEF00D, 1'b1,1'b0,32'h40,4'b0000,32'h0,        1, 2, 1'b1, 32'h50, 4'b1111, 32'hCAFEF00D};
        vecs[11] = '{1'b0,1'b1,1'b0,32'h50,4'b0000,32'h0,        1'b1,1'b0,32'h20,4'b0000,32'h0,        1, 3, 1'b0, 32'h50, 4'b1111, 32'hCAFEF00D};
        vecs[12] = '{1'b1,1'b0,1'b0,32'h0, 4'b0000,32'h0,        1'b1,1'b0,32'h50,4'b0000,32'h0,        2, 3, 1'b0, 32'h50, 4'b1111, 32'hCAFEF00D};

        rst = 1'b1; i_booted = 1'b0; drop_reqs();
        b_addr = 32'd0; b_byte_enable = 4'd0; b_write_data = 32'd0;
        c_addr = 32'd0; c_byte_enable = 4'd0; c_write_data = 32'd0;
        trk_b = 32'd0; trk_c = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Write and read raised together on C: the write goes first.
        i_booted = 1'b1;
        c_read_req = 1'b1; c_write_req = 1'b1; c_addr = 32'h20;
        c_byte_enable = 4'b1111; c_write_data = 32'h12345678;
        watch(12, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        check("rw_first_port", 32'(port), 32'd2);
        check("rw_first_lat",  32'(lat),  32'd2);
        check("rw_first_we",   32'(nwe),  32'd1);
        check("rw_first_wd",   mwd,       32'h12345678);
        c_write_req = 1'b0;
        watch(12, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        check("rw_second_lat",   32'(lat), 32'd4);
        check("rw_second_rd",    32'(nrd), 32'd1);
        check("rw_second_rdata", rdat,     32'h12345678);
        drop_reqs();
        @(negedge clk);

        // Reset while a read is in flight.
        b_read_req = 1'b1; b_addr = 32'h10;
        @(negedge clk);
        check("rst_in_read", 32'(m_read_req), 32'd1);
        rst = 1'b1; drop_reqs();
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0; trk_b = 32'd0; trk_c = 32'd0;
        watch(6, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        check("rst_no_done", 32'(port), 32'd0);

        // Both ports hold reads: strict alternation starting with B after reset.
        b_read_req = 1'b1; b_addr = 32'h10;
        c_read_req = 1'b1; c_addr = 32'h20;
        cb = 0; cc = 0;
        for (int t = 0; t < 20; t++) begin
            watch(10, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
            check($sformatf("rr%0d_port", t), 32'(port), (t % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_rdata", t), rdat, (t % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
            if (port == 1) cb++;
            if (port == 2) cc++;
        end
        check("rr_b_count", 32'(cb), 32'd10);
        check("rr_c_count", 32'(cc), 32'd10);
        drop_reqs();
        @(negedge clk);

        // Boot drops while a C read is in flight.
        c_read_req = 1'b1; c_addr = 32'h20;
        @(negedge clk);
        i_booted = 1'b0;
        watch(10, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        check("boot_c_port",  32'(port), 32'd2);
        check("boot_c_lat",   32'(lat),  32'd2);
        check("boot_c_rdata", rdat,      32'h12345678);
        b_read_req = 1'b1; b_addr = 32'h40;
        watch(10, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        check("boot_b_port",  32'(port), 32'd1);
        check("boot_b_lat",   32'(lat),  32'd4);
        check("boot_b_rdata", rdat,      32'hA5A55A5A);
        b_read_req = 1'b0;
        watch(8, lat, port, nwe, nrd, ma, mbe, mwd, rdat);
        check("boot_c_ignored", 32'(port), 32'd0);
        drop_reqs();

        // Three-cycle read latency on the second instance.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b_read_req = 1'b1; b_addr = 32'h10;
        lat3 = 0; nrd3 = 0; rd3 = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (d3_m_rd) nrd3++;
            check($sformatf("rl3_c_done_%0d", k), 32'(d3_c_done), 32'd0);
            if (d3_b_done) begin
                lat3 = k; rd3 = d3_b_rd;
                break;
            end
        end
        drop_reqs();
        check("rl3_lat",   32'(lat3), 32'd5);
        check("rl3_rd",    32'(nrd3), 32'd1);
        check("rl3_rdata", rd3,       32'hDEADBEEF);
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port between two requesters: port B (serial BIOS loader) and port C (CPU core).
- Before boot, only B is serviced. After boot, B and C are serviced round-robin.
- Each access runs as one registered transaction: write, or read with fixed latency. Completion is reported per port with a one-cycle grant/valid pulse.
- Sits between the BIOS loader, the core and the RAM wrapper in the top level.

Parameters:
- ADDR_WIDTH, 31, MSB index of address buses (buses are [ADDR_WIDTH:0]).
- DATA_WIDTH, 31, MSB index of data buses.
- READ_LATENCY, 1, cycles from m_read_req high to RAM read data valid (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_booted  in  1  level; 1 = boot complete, CPU port may be serviced
- b_read_req  in  1  BIOS read request, held until o_b_done
- b_write_req  in  1  BIOS write request, held until o_b_done
- b_addr  in  ADDR_WIDTH+1  BIOS address
- b_byte_enable  in  4  BIOS write byte lanes
- b_write_data  in  DATA_WIDTH+1  BIOS write data
- o_b_done  out  1  one-cycle completion pulse for BIOS
- o_b_read_data  out  DATA_WIDTH+1  BIOS read data, valid while o_b_done (read)
- c_read_req, c_write_req, c_addr, c_byte_enable, c_write_data  in  same widths as B  CPU request
- o_c_done  out  1  CPU completion pulse
- o_c_read_data  out  DATA_WIDTH+1  CPU read data
- m_read_req  out  1  RAM read strobe
- m_write_enable  out  1  RAM write strobe
- m_byte_enable  out  4  RAM byte lanes
- m_addr  out  ADDR_WIDTH+1  RAM address (shared read/write)
- m_write_data  out  DATA_WIDTH+1  RAM write data
- i_read_data  in  DATA_WIDTH+1  RAM read data

Behaviour:
- Reset: state ARB_IDLE, last_grant=C (so B wins the first tie). All m_* and o_* outputs are 0, including data buses. Reset aborts any in-flight transaction with no done pulse.
- States: ARB_IDLE, ARB_WRITE, ARB_READ, ARB_DONE.
- ARB_IDLE, eligibility:
  - B is eligible if b_read_req|b_write_req.
  - C is eligible if (c_read_req|c_write_req) & i_booted.
- ARB_IDLE, winner selection:
  - Exactly one eligible: it wins.
  - Both eligible: the port other than last_grant wins.
- ARB_IDLE, launch: register the winner's addr, byte_enable, write_data and a read/write flag into m_*, update last_grant.
  - Write → ARB_WRITE. Read → ARB_READ, with latency counter = READ_LATENCY.
  - Read and write both high on one port: write is serviced; the read remains pending for a later transaction.
- ARB_WRITE: m_write_enable=1 for exactly this cycle, then → ARB_DONE.
- ARB_READ:
  - m_read_req=1 for the first cycle only; m_addr stays held. Counter decrements each cycle.
  - At 0, capture i_read_data into the winner's o_*_read_data → ARB_DONE.
- ARB_DONE: o_<winner>_done=1 for one cycle, m_* strobes 0 → ARB_IDLE.
- Total latency: request seen in IDLE at cycle N.
  - Write done pulse at N+2.
  - Read done pulse at N+2+READ_LATENCY.
  - No back-to-back issue; the minimum gap between transactions is the ARB_DONE+ARB_IDLE cycles.
- Requester rules:
  - Request and payload are held stable until done.
  - The requester deasserts req in the cycle after done, or keeps it high for a new access. A held req after done is treated as a new request.
- o_*_read_data holds its last captured value between reads. It is not cleared by writes.
- i_booted falling mid-transaction: the current transaction completes normally; C is ineligible from the next IDLE.
- A request dropped mid-transaction has no effect; the transaction still completes and pulses done.
- m_byte_enable for reads = 4'b1111.

Decomposition:
- Shared package bios_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_WRITE, ARB_READ, ARB_DONE};
  - typedef enum arb_port_t {PORT_B, PORT_C};
  - packed struct ram_req_t {addr, byte_enable, write_data, is_write}, for muxing and registering.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin selector (eligible[1:0], last_grant → winner, any).
- The FSM, latency counter and registers stay in ram_port_arbiter.

Test Plan:
- Pre-boot isolation: i_booted=0; b_write_req addr=0x10, data=0xDEADBEEF, be=4'b0001 with c_read_req held → m_write_enable one pulse with addr 0x10, o_b_done at N+2, o_c_done never asserts.
- Read latency: READ_LATENCY=1; B reads addr 0x10 with the RAM model returning 0xDEADBEEF → m_read_req single pulse, o_b_read_data=0xDEADBEEF with o_b_done at N+3. Repeat with READ_LATENCY=3 → done at N+5.
- Round-robin: i_booted=1; B and C hold read requests continuously → grant sequence B,C,B,C; each port's done count differs by at most 1 after 20 transactions.
- Simultaneous R/W on one port: C asserts both write (addr 0x20, 0x12345678) and read (addr 0x20) → write serviced first; the following read returns 0x12345678.
- Reset mid-read: assert rst during ARB_READ → next cycle all outputs 0, no done pulse, state IDLE; the first post-reset tie goes to B.
- Boot drop: i_booted 1→0 while a C read is in flight → C done still pulses; subsequent C requests are ignored while B requests are serviced.
